// File: rtl/tensor_core_pkg.sv
// -----------------------------------------------------------------------------
// tensor_core_pkg
// Shared types and constants for the tensor core register file and its
// helpers: element type, matrix geometry and the drain FSM state encoding.
//
// Configuration macro: TENSOR_CORE_DRAIN_CHECKSUM_EN adds the CHECKSUM state
// used by the drain's trailing XOR beat.
// -----------------------------------------------------------------------------
package tensor_core_pkg;

    localparam int BUS_WIDTH       = 8;
    localparam int MATRIX_DIM      = 4;
    localparam int REGS_PER_MATRIX = 16;
    localparam int DIM_W           = $clog2(MATRIX_DIM);

    typedef logic signed [BUS_WIDTH-1:0] tensor_element_t;

`ifdef TENSOR_CORE_DRAIN_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, STREAM, CHECKSUM} drain_state_e;
`else
    typedef enum logic {IDLE, STREAM} drain_state_e;
`endif

    // Number of 4x4 matrices needed to hold n registers.
    function automatic int num_matrices(input int n);
        return (n - 1) / REGS_PER_MATRIX + 1;
    endfunction

    // Width of a matrix index; kept at least 1 bit so a single-matrix
    // register file still has a legal port.
    function automatic int matrix_index_width(input int n);
        return (num_matrices(n) > 1) ? $clog2(num_matrices(n)) : 1;
    endfunction

endpackage

// File: rtl/tensor_core_flat_index_decode.sv
// -----------------------------------------------------------------------------
// tensor_core_flat_index_decode
// Maps a flat register index a = n*16 + i*4 + j onto the [n][i][j] element of
// the register file. Purely combinational; shared with the register file's
// byte-serial ports so both sides agree on the layout.
//
// Ports:
//   flat_index_in  flat register index
//   matrix_out     matrix number n
//   row_out        row i within the matrix
//   column_out     column j within the row
// -----------------------------------------------------------------------------
module tensor_core_flat_index_decode
    import tensor_core_pkg::*;
#(
    parameter int  NUMBER_OF_REGISTERS = 32,
    localparam int ADDR_W              = $clog2(NUMBER_OF_REGISTERS),
    localparam int MAT_W               = matrix_index_width(NUMBER_OF_REGISTERS)
) (
    input  logic [ADDR_W-1:0] flat_index_in,
    output logic [MAT_W-1:0]  matrix_out,
    output logic [DIM_W-1:0]  row_out,
    output logic [DIM_W-1:0]  column_out
);

    always_comb begin
        matrix_out = MAT_W'(flat_index_in / REGS_PER_MATRIX);
        row_out    = DIM_W'((flat_index_in / MATRIX_DIM) % MATRIX_DIM);
        column_out = DIM_W'(flat_index_in % MATRIX_DIM);
    end

endmodule

// File: rtl/tensor_core_register_file_drain.sv
// -----------------------------------------------------------------------------
// tensor_core_register_file_drain
// Snapshots the register file's bulk read bus on a start pulse, then streams
// a window of registers out one byte per beat over valid/ready. The snapshot
// decouples the drain from the tensor core, which may keep writing.
//
// Ports:
//   clock_in           clock, all state on posedge
//   reset_in           synchronous active-high reset, aborts any drain
//   start_in           snapshot and start a drain (honoured only when idle)
//   start_address_in   flat index of first register emitted
//   length_in          registers to emit, 0 means NUMBER_OF_REGISTERS
//   bulk_read_data_in  register file bulk read bus [matrix][row][col]
//   data_out           current byte
//   valid_out          data_out / last_out valid
//   ready_in           downstream accepts when valid_out && ready_in
//   last_out           final beat of the drain
//   busy_out           drain in progress
//   done_out           one-cycle pulse after the final beat is accepted
//
// Configuration macro: TENSOR_CORE_DRAIN_CHECKSUM_EN appends one beat holding
// the XOR of all emitted bytes; last_out and done_out move to that beat.
// -----------------------------------------------------------------------------
module tensor_core_register_file_drain
    import tensor_core_pkg::*;
#(
    parameter int  NUMBER_OF_REGISTERS = 32,
    localparam int NUM_MATRICES        = num_matrices(NUMBER_OF_REGISTERS),
    localparam int ADDR_W              = $clog2(NUMBER_OF_REGISTERS),
    localparam int COUNT_W             = ADDR_W + 1,
    localparam int MAT_W               = matrix_index_width(NUMBER_OF_REGISTERS)
) (
    input  logic                clock_in,
    input  logic                reset_in,
    input  logic                start_in,
    input  logic [ADDR_W-1:0]   start_address_in,
    input  logic [COUNT_W-1:0]  length_in,
    input  tensor_element_t     bulk_read_data_in [NUM_MATRICES][MATRIX_DIM][MATRIX_DIM],
    output tensor_element_t     data_out,
    output logic                valid_out,
    input  logic                ready_in,
    output logic                last_out,
    output logic                busy_out,
    output logic                done_out
);

    drain_state_e    state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic            done_q, done_d;
    logic            load_snapshot;
    tensor_element_t snapshot_q [NUM_MATRICES][MATRIX_DIM][MATRIX_DIM];
`ifdef TENSOR_CORE_DRAIN_CHECKSUM_EN
    tensor_element_t xor_q, xor_d;
`endif

    logic [MAT_W-1:0] sel_matrix;
    logic [DIM_W-1:0] sel_row;
    logic [DIM_W-1:0] sel_column;
    tensor_element_t  snap_byte;
    logic [ADDR_W-1:0] ptr_next;

    tensor_core_flat_index_decode #(
        .NUMBER_OF_REGISTERS(NUMBER_OF_REGISTERS)
    ) u_decode (
        .flat_index_in(ptr_q),
        .matrix_out   (sel_matrix),
        .row_out      (sel_row),
        .column_out   (sel_column)
    );

    assign snap_byte = snapshot_q[sel_matrix][sel_row][sel_column];

    // Explicit wrap keeps non-power-of-2 sizes correct; for powers of 2 it
    // reduces to the natural rollover.
    assign ptr_next = (ptr_q == ADDR_W'(NUMBER_OF_REGISTERS - 1)) ? '0 : ptr_q + 1'b1;

    assign done_out = done_q;

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would infer a latch.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        count_d       = count_q;
        done_d        = 1'b0;
        load_snapshot = 1'b0;
        data_out      = snap_byte;
        valid_out     = 1'b0;
        last_out      = 1'b0;
        busy_out      = 1'b0;
`ifdef TENSOR_CORE_DRAIN_CHECKSUM_EN
        xor_d         = xor_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    load_snapshot = 1'b1;
                    ptr_d         = start_address_in;
                    count_d       = (length_in == '0) ? COUNT_W'(NUMBER_OF_REGISTERS) : length_in;
                    state_d       = STREAM;
`ifdef TENSOR_CORE_DRAIN_CHECKSUM_EN
                    xor_d         = '0;
`endif
                end
            end
            STREAM: begin
                valid_out = 1'b1;
                busy_out  = 1'b1;
`ifndef TENSOR_CORE_DRAIN_CHECKSUM_EN
                last_out  = (count_q == COUNT_W'(1));
`endif
                if (ready_in) begin
                    ptr_d   = ptr_next;
                    count_d = count_q - 1'b1;
`ifdef TENSOR_CORE_DRAIN_CHECKSUM_EN
                    xor_d   = xor_q ^ snap_byte;
                    if (count_q == COUNT_W'(1)) state_d = CHECKSUM;
`else
                    if (count_q == COUNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
`ifdef TENSOR_CORE_DRAIN_CHECKSUM_EN
            CHECKSUM: begin
                valid_out = 1'b1;
                busy_out  = 1'b1;
                last_out  = 1'b1;
                data_out  = xor_q;
                if (ready_in) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
`ifdef TENSOR_CORE_DRAIN_CHECKSUM_EN
            xor_q   <= '0;
`endif
            // NOTE: the snapshot storage is reset on purpose so data_out
            // reads 0 after reset; plain register-file arrays usually skip this.
            foreach (snapshot_q[n, i, j]) snapshot_q[n][i][j] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            done_q  <= done_d;
`ifdef TENSOR_CORE_DRAIN_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
            if (load_snapshot) snapshot_q <= bulk_read_data_in;
        end
    end

endmodule

// File: tb/tb_tensor_core_register_file_drain.sv
// -----------------------------------------------------------------------------
// tb_tensor_core_register_file_drain
// Self-checking bench for the register file drain. A flat byte array models
// the register file; each drain's expected beat list is built from it at
// start time (index wrap, length 0 = all registers, optional XOR beat).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tensor_core_register_file_drain;
    import tensor_core_pkg::*;

    localparam int N       = 32;
    localparam int NM      = (N - 1) / 16 + 1;
    localparam int ADDR_W  = $clog2(N);
    localparam int COUNT_W = ADDR_W + 1;

    logic                clk = 1'b0;
    logic                reset_in = 1'b1;
    logic                start_in = 1'b0;
    logic [ADDR_W-1:0]   start_address_in = '0;
    logic [COUNT_W-1:0]  length_in = '0;
    tensor_element_t     bulk [NM][4][4];
    tensor_element_t     data_out;
    logic                valid_out;
    logic                ready_in = 1'b0;
    logic                last_out;
    logic                busy_out;
    logic                done_out;

    logic [7:0] model_mem [N];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tensor_core_register_file_drain #(.NUMBER_OF_REGISTERS(N)) dut (
        .clock_in         (clk),
        .reset_in         (reset_in),
        .start_in         (start_in),
        .start_address_in (start_address_in),
        .length_in        (length_in),
        .bulk_read_data_in(bulk),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .last_out         (last_out),
        .busy_out         (busy_out),
        .done_out         (done_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present the model contents on the bulk bus using the flat mapping.
    task automatic drive_bulk_from_model();
        for (int a = 0; a < N; a++) bulk[a / 16][(a / 4) % 4][a % 4] = model_mem[a];
    endtask

    task automatic drive_bulk_all(input logic [7:0] v);
        for (int a = 0; a < N; a++) bulk[a / 16][(a / 4) % 4][a % 4] = v;
    endtask

    // ready_mode: 0 = always ready, 1 = toggle, 2 = random.
    // abort_beat >= 0 asserts reset while that beat is presented.
    task automatic run_drain(input int addr, input int len, input int ready_mode,
                             input bit overwrite, input bit poke_start,
                             input bit start_on_last, input int abort_beat);
        logic [7:0] exp_q [$];
        logic [7:0] x;
        logic [7:0] b;
        int l;
        int idx;
        int cyc;
        bit r;
        l = (len == 0) ? N : len;
        x = '0;
        for (int k = 0; k < l; k++) begin
            b = model_mem[(addr + k) % N];
            exp_q.push_back(b);
            x ^= b;
        end
`ifdef TENSOR_CORE_DRAIN_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        start_in         = 1'b1;
        start_address_in = ADDR_W'(addr);
        length_in        = COUNT_W'(len);
        @(negedge clk);
        start_in = 1'b0;
        if (overwrite) drive_bulk_all(8'hFF);
        idx = 0;
        cyc = 0;
        while (idx < exp_q.size() && cyc < 400) begin
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = cyc[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            ready_in = r;
            start_in = poke_start && (cyc == 3);
            if (start_in) start_address_in = ADDR_W'(addr + 5);
            check("valid", 32'(valid_out), 32'd1);
            check("busy", 32'(busy_out), 32'd1);
            check($sformatf("data[%0d]", idx), {24'h0, data_out}, {24'h0, exp_q[idx]});
            check($sformatf("last[%0d]", idx), 32'(last_out), 32'(idx == exp_q.size() - 1));
            if (abort_beat >= 0 && idx == abort_beat) begin
                reset_in = 1'b1;
                @(negedge clk);
                reset_in = 1'b0;
                check("abort_valid", 32'(valid_out), 32'd0);
                check("abort_busy", 32'(busy_out), 32'd0);
                check("abort_done", 32'(done_out), 32'd0);
                check("abort_data", {24'h0, data_out}, 32'd0);
                @(negedge clk);
                check("abort_done_later", 32'(done_out), 32'd0);
                return;
            end
            if (start_on_last && r && idx == exp_q.size() - 1) start_in = 1'b1;
            if (r) idx++;
            cyc++;
            @(negedge clk);
        end
        start_in = 1'b0;
        check("beats_accepted", 32'(idx), 32'(exp_q.size()));
        check("done_pulse", 32'(done_out), 32'd1);
        check("end_valid", 32'(valid_out), 32'd0);
        check("end_busy", 32'(busy_out), 32'd0);
        @(negedge clk);
        check("done_single", 32'(done_out), 32'd0);
        check("idle_valid", 32'(valid_out), 32'd0);
    endtask

    initial begin
        for (int a = 0; a < N; a++) model_mem[a] = 8'(a);
        drive_bulk_from_model();

        // Reset state, checked while reset is still held.
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_last", 32'(last_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_data", {24'h0, data_out}, 32'd0);
        reset_in = 1'b0;
        @(negedge clk);

        // Full drain at full throughput, length 0 meaning all registers.
        run_drain(0, 0, 0, 1'b0, 1'b0, 1'b0, -1);
        // Wrap-around window, plus a start on the final handshake edge.
        run_drain(30, 4, 0, 1'b0, 1'b0, 1'b1, -1);
        // Backpressure with ready toggling every other cycle.
        run_drain(7, 10, 1, 1'b0, 1'b0, 1'b0, -1);

        // Snapshot immunity and start ignored while busy.
        for (int a = 0; a < N; a++) model_mem[a] = 8'($urandom);
        drive_bulk_from_model();
        run_drain(3, 12, 2, 1'b1, 1'b1, 1'b0, -1);
        drive_bulk_from_model();

        // Reset on the 5th beat of a 16-beat drain, then a fresh drain.
        run_drain(0, 16, 0, 1'b0, 1'b0, 1'b0, 4);
        run_drain(16, 16, 0, 1'b0, 1'b0, 1'b0, -1);

        // Random windows, data and backpressure.
        for (int t = 0; t < 6; t++) begin
            for (int a = 0; a < N; a++) model_mem[a] = 8'($urandom);
            drive_bulk_from_model();
            run_drain(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N)), 2,
                      1'b0, 1'b0, 1'b0, -1);
        end

        // Short directed drain; with the checksum beat it ends with 8'h70.
        model_mem[0] = 8'h12;
        model_mem[1] = 8'h34;
        model_mem[2] = 8'h56;
        drive_bulk_from_model();
        run_drain(0, 3, 0, 1'b0, 1'b0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
